// File: rtl/i2c_cmd_scheduler_if.sv
// Command-enqueue and issue buses between a command source and the I2C scheduler.
interface i2c_cmd_scheduler_if #(
  parameter int DW = 16
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_addr;
  logic [7:0]    cmd_mode;
  logic [DW-1:0] cmd_data;

  logic          issue_valid;
  logic          issue_src;
  logic [7:0]    issue_addr;
  logic [7:0]    issue_mode;
  logic [DW-1:0] issue_data;

  modport master (
    output cmd_valid, cmd_addr, cmd_mode, cmd_data,
    input  cmd_ready,
    input  issue_valid, issue_src, issue_addr, issue_mode, issue_data
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_mode, cmd_data,
    output cmd_ready,
    output issue_valid, issue_src, issue_addr, issue_mode, issue_data
  );
endinterface

// File: rtl/i2c_cmd_scheduler.sv
// Queues I2C commands and interleaves periodic temperature polls, issuing one at a time.
// Push-to-issue latency 2 cycles; cmd_ready drops at DEPTH and extra commands are dropped (overflow).
module i2c_cmd_scheduler #(
  parameter int         DEPTH     = 4,
  parameter int         DW        = 16,
  parameter int         POLL_DIV  = 1000,
  parameter logic [7:0] POLL_ADDR = 8'h00,
  parameter logic [7:0] POLL_MODE = 8'h01,
  parameter int         MAX_BURST = 4,
  parameter int         ACK_TMO   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  i2c_cmd_scheduler_if.slave     bus,
  input  logic                   poll_en,
  input  logic                   clr_err,
  input  logic                   i2c_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   ack_timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 16 + DW;
  localparam int TW = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int KW = $clog2(ACK_TMO + 1);
  localparam logic [AW:0]   FULL   = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] RELOAD = TW'(POLL_DIV - 1);
  localparam logic [BW-1:0] BMAX   = BW'(MAX_BURST);
  localparam logic [KW-1:0] KLAST  = KW'(ACK_TMO - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] tmr;
  logic          poll_pending;
  logic [BW-1:0] burst_cnt;
  logic [KW-1:0] tmo_cnt;

  logic          push, start, take_poll, take_q, tmr_exp;
  logic [EW-1:0] head;

  assign bus.cmd_ready = (count != FULL);
  assign push      = bus.cmd_valid && bus.cmd_ready;
  assign start     = (state == IDLE) && i2c_ready && ((count != '0) || poll_pending);
  assign take_poll = start && poll_pending && ((count == '0) || (burst_cnt == BMAX));
  assign take_q    = start && !take_poll;
  assign tmr_exp   = poll_en && (tmr == '0);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.cmd_addr, bus.cmd_mode, bus.cmd_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      tmr             <= RELOAD;
      poll_pending    <= 1'b0;
      burst_cnt       <= '0;
      tmo_cnt         <= '0;
      overflow        <= 1'b0;
      ack_timeout     <= 1'b0;
      bus.issue_valid <= 1'b0;
      bus.issue_src   <= 1'b0;
      bus.issue_addr  <= '0;
      bus.issue_mode  <= '0;
      bus.issue_data  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (take_q) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW + 1)'(push) - (AW + 1)'(take_q);

      // Clears are written first so a same-cycle set below overrides them.
      if (clr_err) begin
        overflow    <= 1'b0;
        ack_timeout <= 1'b0;
      end
      if (bus.cmd_valid && !bus.cmd_ready) overflow <= 1'b1;

      if (!poll_en) begin
        tmr          <= RELOAD;
        poll_pending <= 1'b0;
      end else begin
        tmr <= tmr_exp ? RELOAD : tmr - TW'(1);
        if (tmr_exp)        poll_pending <= 1'b1;
        else if (take_poll) poll_pending <= 1'b0;
      end

      if (!poll_pending || take_poll)      burst_cnt <= '0;
      else if (take_q && burst_cnt != BMAX) burst_cnt <= burst_cnt + BW'(1);

      case (state)
        IDLE: begin
          if (start) begin
            state           <= ISSUE;
            bus.issue_valid <= 1'b1;
            bus.issue_src   <= take_poll;
            bus.issue_addr  <= take_poll ? POLL_ADDR : head[EW-1 -: 8];
            bus.issue_mode  <= take_poll ? POLL_MODE : head[EW-9 -: 8];
            bus.issue_data  <= take_poll ? '0 : head[DW-1:0];
          end
        end
        ISSUE: begin
          state           <= WAIT_BUSY;
          tmo_cnt         <= '0;
          bus.issue_valid <= 1'b0;
          bus.issue_src   <= 1'b0;
          bus.issue_addr  <= '0;
          bus.issue_mode  <= '0;
          bus.issue_data  <= '0;
        end
        WAIT_BUSY: begin
          // A controller that never goes busy is abandoned; the command is not retried.
          if (!i2c_ready) begin
            state <= WAIT_DONE;
          end else if (tmo_cnt == KLAST) begin
            state       <= IDLE;
            ack_timeout <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + KW'(1);
          end
        end
        WAIT_DONE: begin
          if (i2c_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_cmd_scheduler.sv
// Scoreboard bench: stimulus queues expected issues, a negedge monitor pops and compares.
module tb_i2c_cmd_scheduler;
  localparam int DEPTH = 4, DW = 16, POLL_DIV = 10, MAX_BURST = 4, ACK_TMO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       poll_en = 1'b0, clr_err = 1'b0, i2c_ready = 1'b1;
  logic [2:0] count;
  logic       overflow, ack_timeout;

  i2c_cmd_scheduler_if #(.DW(DW)) bus ();

  i2c_cmd_scheduler #(
    .DEPTH(DEPTH), .DW(DW), .POLL_DIV(POLL_DIV), .POLL_ADDR(8'h00),
    .POLL_MODE(8'h01), .MAX_BURST(MAX_BURST), .ACK_TMO(ACK_TMO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .poll_en(poll_en), .clr_err(clr_err),
    .i2c_ready(i2c_ready), .count(count), .overflow(overflow), .ack_timeout(ack_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        src;
    logic [7:0]  addr;
    logic [7:0]  mode;
    logic [15:0] data;
    int          ecyc;
    int          gap;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0, miscompares = 0, n_seen = 0, last_cyc = -1000;
  bit   hold_busy = 0, no_ack = 0, prev_vld = 0;
  int   busy_left = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_issue(input logic src, input logic [7:0] a, input logic [7:0] m,
                              input logic [15:0] d, input int ecyc, input int gap);
    exp_t e;
    e.src = src; e.addr = a; e.mode = m; e.data = d; e.ecyc = ecyc; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic push_cmd(input logic [7:0] a, input logic [7:0] m, input logic [15:0] d,
                          output int acc_cyc);
    int w;
    w = 0;
    bus.cmd_valid = 1'b1; bus.cmd_addr = a; bus.cmd_mode = m; bus.cmd_data = d;
    while (bus.cmd_ready !== 1'b1 && w < 200) begin
      tick(1);
      w++;
    end
    if (w >= 200) begin
      vectors++; miscompares++;
      $display("FAIL push_wait: cmd_ready=%b after 200 cycles, required 1", bus.cmd_ready);
    end
    tick(1);
    acc_cyc = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_seen(input int target, input int budget);
    int w;
    w = 0;
    while (n_seen < target && w < budget) begin
      tick(1);
      w++;
    end
    if (n_seen < target) begin
      vectors++; miscompares++;
      $display("FAIL wait_issue: saw %0d issues, required %0d", n_seen, target);
    end
  endtask

  task automatic drain(input int budget);
    int w;
    w = 0;
    while (sb.size() > 0 && w < budget) begin
      tick(1);
      w++;
    end
    if (sb.size() > 0) begin
      vectors++; miscompares++;
      $display("FAIL drain: %0d expected issues outstanding, required 0", sb.size());
      sb.delete();
    end
    tick(8);
  endtask

  // Controller model: goes busy for 3 cycles after each issue unless forced.
  always @(negedge clk) begin
    if (hold_busy) begin
      i2c_ready = 1'b0;
      busy_left = 0;
    end else if (no_ack) begin
      i2c_ready = 1'b1;
    end else if (bus.issue_valid === 1'b1) begin
      i2c_ready = 1'b0;
      busy_left = 3;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) i2c_ready = 1'b1;
    end else begin
      i2c_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (bus.issue_valid === 1'b1) begin
      n_seen++;
      if (sb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_issue: got src=%0d addr=%0h mode=%0h data=%0h, required none",
                 bus.issue_src, bus.issue_addr, bus.issue_mode, bus.issue_data);
      end else begin
        mon_e = sb.pop_front();
        check("issue_src", 40'(bus.issue_src), 40'(mon_e.src));
        check("issue_addr", 40'(bus.issue_addr), 40'(mon_e.addr));
        check("issue_mode", 40'(bus.issue_mode), 40'(mon_e.mode));
        check("issue_data", 40'(bus.issue_data), 40'(mon_e.data));
        if (mon_e.ecyc >= 0) check("issue_latency", 40'(cyc), 40'(mon_e.ecyc));
        if (mon_e.gap >= 0)  check("issue_gap", 40'(cyc - last_cyc), 40'(mon_e.gap));
      end
      check("issue_pulse_width", 40'(prev_vld), 40'(0));
      last_cyc = cyc;
    end else if (!reset) begin
      check("idle_outputs_zero",
            40'({bus.issue_src, bus.issue_addr, bus.issue_mode, bus.issue_data}), 40'(0));
    end
    prev_vld = (bus.issue_valid === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required self-termination");
    $fatal(1);
  end

  initial begin
    int acc, base;
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_mode = '0; bus.cmd_data = '0;
    tick(3);
    check("rst_count", 40'(count), 40'(0));
    check("rst_cmd_ready", 40'(bus.cmd_ready), 40'(1));
    check("rst_overflow", 40'(overflow), 40'(0));
    check("rst_ack_timeout", 40'(ack_timeout), 40'(0));
    check("rst_issue_valid", 40'(bus.issue_valid), 40'(0));
    reset = 1'b0;
    tick(2);

    // Single command into an idle scheduler: two-cycle latency.
    push_cmd(8'h01, 8'h02, 16'h1234, acc);
    expect_issue(1'b0, 8'h01, 8'h02, 16'h1234, acc + 1, -1);
    drain(50);

    // Fill with controller stalled, overflow on the 5th, then drop-while-popping.
    hold_busy = 1; tick(2);
    for (int k = 0; k < 5; k++) begin
      bus.cmd_valid = 1'b1; bus.cmd_addr = 8'h10 + 8'(k);
      bus.cmd_mode = 8'h20 + 8'(k); bus.cmd_data = 16'hA000 + 16'(k);
      tick(1);
    end
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++)
      expect_issue(1'b0, 8'h10 + 8'(k), 8'h20 + 8'(k), 16'hA000 + 16'(k), -1, -1);
    check("full_count", 40'(count), 40'(4));
    check("full_cmd_ready", 40'(bus.cmd_ready), 40'(0));
    check("overflow_set", 40'(overflow), 40'(1));
    clr_err = 1'b1; tick(1); clr_err = 1'b0;
    check("overflow_cleared", 40'(overflow), 40'(0));
    hold_busy = 0;
    bus.cmd_valid = 1'b1; bus.cmd_addr = 8'hDE; bus.cmd_mode = 8'hAD; bus.cmd_data = 16'hDEAD;
    tick(1);
    bus.cmd_valid = 1'b0;
    check("drop_pop_count", 40'(count), 40'(3));
    check("drop_pop_overflow", 40'(overflow), 40'(1));
    drain(100);
    clr_err = 1'b1; tick(1); clr_err = 1'b0;

    // Controller never goes busy: each issue times out after ACK_TMO cycles.
    no_ack = 1; tick(2);
    push_cmd(8'h31, 8'h41, 16'h5151, acc);
    expect_issue(1'b0, 8'h31, 8'h41, 16'h5151, acc + 1, -1);
    push_cmd(8'h32, 8'h42, 16'h5252, acc);
    expect_issue(1'b0, 8'h32, 8'h42, 16'h5252, -1, 18);
    drain(100);
    tick(12);
    check("ack_timeout_set", 40'(ack_timeout), 40'(1));
    clr_err = 1'b1; tick(1); clr_err = 1'b0;
    check("ack_timeout_cleared", 40'(ack_timeout), 40'(0));
    no_ack = 0; tick(2);

    // Polls alone, one every POLL_DIV cycles.
    base = n_seen;
    expect_issue(1'b1, 8'h00, 8'h01, 16'h0000, -1, -1);
    expect_issue(1'b1, 8'h00, 8'h01, 16'h0000, -1, 10);
    expect_issue(1'b1, 8'h00, 8'h01, 16'h0000, -1, 10);
    poll_en = 1'b1;
    wait_seen(base + 3, 100);
    poll_en = 1'b0;
    drain(50);

    // Poll pending with a busy queue: MAX_BURST queued, one poll, queued resumes.
    hold_busy = 1; tick(2);
    poll_en = 1'b1;
    base = n_seen;
    for (int k = 0; k < 4; k++) begin
      push_cmd(8'h50 + 8'(k), 8'h60 + 8'(k), 16'hB000 + 16'(k), acc);
      expect_issue(1'b0, 8'h50 + 8'(k), 8'h60 + 8'(k), 16'hB000 + 16'(k), -1, -1);
    end
    expect_issue(1'b1, 8'h00, 8'h01, 16'h0000, -1, -1);
    expect_issue(1'b0, 8'h54, 8'h64, 16'hB004, -1, -1);
    expect_issue(1'b0, 8'h55, 8'h65, 16'hB005, -1, -1);
    tick(12);
    hold_busy = 0;
    push_cmd(8'h54, 8'h64, 16'hB004, acc);
    push_cmd(8'h55, 8'h65, 16'hB005, acc);
    wait_seen(base + 5, 100);
    poll_en = 1'b0;
    drain(100);

    // Reset while waiting for the controller with three entries queued.
    hold_busy = 1; tick(2);
    for (int k = 0; k < 4; k++)
      push_cmd(8'h70 + 8'(k), 8'h80 + 8'(k), 16'hC000 + 16'(k), acc);
    expect_issue(1'b0, 8'h70, 8'h80, 16'hC000, -1, -1);
    base = n_seen;
    hold_busy = 0;
    wait_seen(base + 1, 50);
    hold_busy = 1;
    tick(4);
    check("pre_reset_count", 40'(count), 40'(3));
    reset = 1'b1;
    tick(1);
    check("mid_reset_count", 40'(count), 40'(0));
    check("mid_reset_issue_valid", 40'(bus.issue_valid), 40'(0));
    check("mid_reset_cmd_ready", 40'(bus.cmd_ready), 40'(1));
    reset = 1'b0;
    hold_busy = 0;
    tick(2);
    push_cmd(8'h99, 8'h98, 16'h9797, acc);
    expect_issue(1'b0, 8'h99, 8'h98, 16'h9797, acc + 1, -1);
    drain(50);
    check("final_count", 40'(count), 40'(0));
    check("scoreboard_empty", 40'(sb.size()), 40'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
